// File: rtl/epd_frame_sequencer.sv
// Purpose: e-paper panel timing sequencer; per frame a 4-cycle SPV/CKV start, then per row shift, latch and gate pulse.
// Latency: all panel/status outputs are registered, one cycle behind the edge that decides them.
// Backpressure: pix_ready only in LDATA between cl pulses (max one byte per 2 cycles); stalls indefinitely on pix_valid=0.
module epd_frame_sequencer #(
  parameter int LINE_BYTES = 200,
  parameter int ROWS       = 600,
  parameter int LE_CYCLES  = 2,
  parameter int CKV_ON     = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] frames,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       ckv,
  output logic       spv,
  output logic       le,
  output logic       sph,
  output logic       cl,
  output logic [7:0] d,
  output logic       busy,
  output logic       done,
  output logic [9:0] row,
  output logic [7:0] frame
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FSTART   = 3'd1;
  localparam logic [2:0] S_LDATA    = 3'd2;
  localparam logic [2:0] S_LATCH    = 3'd3;
  localparam logic [2:0] S_GATE_ON  = 3'd4;
  localparam logic [2:0] S_GATE_OFF = 3'd5;
  localparam logic [2:0] S_FEND     = 3'd6;

  localparam int CW   = $clog2(LINE_BYTES + 1);
  localparam int TMAX = (CKV_ON > LE_CYCLES) ? ((CKV_ON > 4) ? CKV_ON : 4)
                                             : ((LE_CYCLES > 4) ? LE_CYCLES : 4);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(LINE_BYTES);
  localparam logic [TW-1:0] T_FS_LAST  = TW'(3);
  localparam logic [TW-1:0] T_LE_LAST  = TW'(LE_CYCLES - 1);
  localparam logic [TW-1:0] T_ON_LAST  = TW'(CKV_ON - 1);
  localparam logic [TW-1:0] T_OFF_LAST = TW'(1);
  localparam logic [9:0]    ROW_LAST   = 10'(ROWS - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    row_q, row_d;
  logic [7:0]    frame_q, frame_d;
  logic [7:0]    nfr_q, nfr_d;
  logic [7:0]    d_q, d_d;
  logic          cl_q, cl_d;
  logic          ckv_q, ckv_d;
  logic          spv_q, spv_d;
  logic          le_q, le_d;
  logic          sph_q, sph_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;

  // Ready comes from registered state only: open in LDATA while no cl pulse is in flight and the row is short.
  assign pix_ready = (state_q == S_LDATA) && !cl_q && (cnt_q < CNT_LAST);
  assign accept    = pix_valid && pix_ready;

  // Next-state, counters, and output levels decoded from the next state so every output is a flop.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    cnt_d   = cnt_q;
    row_d   = row_q;
    frame_d = frame_q;
    nfr_d   = nfr_q;
    d_d     = d_q;
    cl_d    = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (start && !abort) begin
          if (frames != 8'd0) begin
            nfr_d   = frames;
            state_d = S_FSTART;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FSTART: begin
        if (tmr_q == T_FS_LAST) begin
          state_d = S_LDATA;
          tmr_d   = '0;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      S_LDATA: begin
        tmr_d = '0;
        if (accept) begin
          d_d   = pix_data;
          cl_d  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
        // Leave on the cycle after the last cl high pulse.
        if (cl_q && (cnt_q == CNT_LAST)) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (tmr_q == T_LE_LAST) begin
          state_d = S_GATE_ON;
          tmr_d   = '0;
        end
      end
      S_GATE_ON: begin
        if (tmr_q == T_ON_LAST) begin
          state_d = S_GATE_OFF;
          tmr_d   = '0;
        end
      end
      S_GATE_OFF: begin
        if (tmr_q == T_OFF_LAST) begin
          tmr_d = '0;
          if (row_q < ROW_LAST) begin
            row_d   = row_q + 10'd1;
            cnt_d   = '0;
            state_d = S_LDATA;
          end else begin
            state_d = S_FEND;
          end
        end
      end
      S_FEND: begin
        tmr_d = '0;
        if (({1'b0, frame_q} + 9'd1) < {1'b0, nfr_q}) begin
          frame_d = frame_q + 8'd1;
          row_d   = '0;
          state_d = S_FSTART;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a byte accepted in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end

    if (state_d == S_IDLE) begin
      tmr_d   = '0;
      cnt_d   = '0;
      row_d   = '0;
      frame_d = '0;
      d_d     = '0;
      cl_d    = 1'b0;
    end

    ckv_d  = ((state_d == S_FSTART) && tmr_d[0]) || (state_d == S_GATE_ON);
    spv_d  = !((state_d == S_FSTART) && (tmr_d < TW'(2)));
    le_d   = (state_d == S_LATCH);
    sph_d  = (state_d != S_LDATA);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset forces idle levels without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      frame_q <= '0;
      nfr_q   <= '0;
      d_q     <= '0;
      cl_q    <= 1'b0;
      ckv_q   <= 1'b0;
      spv_q   <= 1'b1;
      le_q    <= 1'b0;
      sph_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      nfr_q   <= nfr_d;
      d_q     <= d_d;
      cl_q    <= cl_d;
      ckv_q   <= ckv_d;
      spv_q   <= spv_d;
      le_q    <= le_d;
      sph_q   <= sph_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ckv   = ckv_q;
  assign spv   = spv_q;
  assign le    = le_q;
  assign sph   = sph_q;
  assign cl    = cl_q;
  assign d     = d_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign row   = row_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_epd_frame_sequencer.sv
// Bench for epd_frame_sequencer: random source traffic, scoreboard of bytes and rows, directed abort/reset cases.
// Timing: inputs change and outputs are sampled on the falling clock edge.
// Flow: accepted bytes and expected (frame,row) pairs are queued; a monitor pops them on cl/le events.
module tb_epd_frame_sequencer;
  localparam int LB  = 4;
  localparam int RW  = 3;
  localparam int LEC = 2;
  localparam int CON = 5;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] frames;
  logic [7:0] pix_data = 8'd0;
  logic       pix_valid = 1'b0;
  logic       pix_ready, ckv, spv, le, sph, cl, busy, done;
  logic [7:0] d, frame;
  logic [9:0] row;

  int total = 0;
  int bad   = 0;

  epd_frame_sequencer #(.LINE_BYTES(LB), .ROWS(RW), .LE_CYCLES(LEC), .CKV_ON(CON)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frames(frames),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ckv(ckv), .spv(spv), .le(le), .sph(sph), .cl(cl), .d(d),
    .busy(busy), .done(done), .row(row), .frame(frame)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] IDLE_V = {31'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 10'd0, 8'd0};

  function automatic logic [63:0] outv();
    return {31'b0, ckv, spv, le, sph, cl, d, pix_ready, busy, row, frame};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=empty expected=queued entry", nm);
  endtask

  logic [7:0]  byte_q[$];
  logic [7:0]  dir_q[$];
  logic [17:0] rowexp_q[$];
  bit mon_en = 1'b0;
  bit av_mode = 1'b0;
  bit stall = 1'b0;

  int n_done, n_fs, n_gate, n_le, cl_in_row, gap, le_run, ckv_run, fs_cnt;
  logic [7:0] fs_hist, exp_b;
  logic       spv_p, le_p, ckv_p;

  // Source driver: random or always-valid traffic, directed bytes first when queued.
  initial forever begin
    @(negedge clk);
    if (stall) pix_valid = 1'b0;
    else if (av_mode) pix_valid = 1'b1;
    else pix_valid = ($urandom_range(0, 3) != 0);
    pix_data = (dir_q.size() > 0) ? dir_q[0] : 8'($urandom);
  end

  // Every accepted byte becomes the expected d value of the next cl pulse.
  always @(posedge clk) begin
    if (pix_valid && pix_ready) begin
      byte_q.push_back(pix_data);
      if (dir_q.size() > 0) void'(dir_q.pop_front());
    end
  end

  // Monitor: pops the scoreboard on cl and le events and measures pulse widths.
  always @(negedge clk) begin
    if (!mon_en) begin
      n_done = 0; n_fs = 0; n_gate = 0; n_le = 0; cl_in_row = 0; gap = 0;
      le_run = 0; ckv_run = 0; fs_cnt = 0; fs_hist = 8'd0;
      spv_p = 1'b1; le_p = 1'b0; ckv_p = 1'b0;
    end else begin
      gap++;
      if (done) n_done++;
      if (cl) begin
        if (byte_q.size() == 0) miss("byte_underflow");
        else begin
          exp_b = byte_q.pop_front();
          chk("d_on_cl", d, exp_b);
        end
        chk("sph_low_on_cl", sph, 0);
        if (av_mode && cl_in_row > 0) chk("cl_spacing", gap, 2);
        cl_in_row++;
        gap = 0;
      end
      if (le && !le_p) begin
        chk("bytes_per_row", cl_in_row, LB);
        chk("le_after_last_cl", gap, 1);
        chk("sph_high_latch", sph, 1);
        if (rowexp_q.size() == 0) miss("row_overflow");
        else chk("frame_row", {frame, row}, rowexp_q.pop_front());
        cl_in_row = 0;
        n_le++;
      end
      if (le) le_run++;
      else if (le_p) begin
        chk("le_width", le_run, LEC);
        le_run = 0;
      end
      if (ckv) ckv_run++;
      else if (ckv_p) begin
        if (ckv_run > 1) begin
          chk("ckv_on_width", ckv_run, CON);
          n_gate++;
        end
        ckv_run = 0;
      end
      if (fs_cnt > 0 || (!spv && spv_p)) begin
        fs_hist = {fs_hist[5:0], spv, ckv};
        fs_cnt++;
        if (fs_cnt == 4) begin
          chk("fstart_pattern", fs_hist, 8'b00_01_10_11);
          n_fs++;
          fs_cnt = 0;
        end
      end
      spv_p = spv; le_p = le; ckv_p = ckv;
    end
  end

  task automatic run_pass(input int nf, input bit av, input bit do_stall);
    int cyc;
    bit seen, ok;
    logic [7:0] held;
    byte_q.delete();
    rowexp_q.delete();
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < RW; r++)
        rowexp_q.push_back({8'(f), 10'(r)});
    av_mode = av;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1; frames = 8'(nf);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (do_stall) begin
      cyc = 0;
      while (!cl && cyc < 500) begin @(negedge clk); cyc++; end
      chk("stall_reached_cl", cl, 1);
      @(posedge clk); #2 stall = 1'b1;
      @(negedge clk);
      held = d;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        start = (i == 5);
        frames = (i == 5) ? 8'd9 : 8'(nf);
        if (cl !== 1'b0 || d !== held || sph !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      end
      start = 1'b0; frames = 8'(nf);
      chk("stall_hold", ok, 1);
      @(posedge clk); #2 stall = 1'b0;
    end
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (done) seen = 1'b1;
    end
    chk("done_within_budget", seen, 1);
    repeat (2) @(negedge clk);
    chk("done_count", n_done, 1);
    chk("fstart_count", n_fs, nf);
    chk("gate_count", n_gate, nf * RW);
    chk("le_count", n_le, nf * RW);
    chk("rows_consumed", rowexp_q.size(), 0);
    chk("bytes_consumed", byte_q.size(), 0);
    chk("idle_after_pass", outv(), IDLE_V);
    mon_en = 1'b0;
    av_mode = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    bit ok;
    rst = 1'b1; start = 1'b0; abort = 1'b0; frames = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_idle", outv(), IDLE_V);
    chk("reset_no_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_release", outv(), IDLE_V);

    // Always-valid source with directed leading bytes.
    dir_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    run_pass(1, 1'b1, 1'b0);
    chk("directed_bytes_used", dir_q.size(), 0);

    // Two frames, random source, 10-cycle stall mid-line plus an ignored start.
    run_pass(2, 1'b0, 1'b1);

    // Abort during GATE_ON of row 1.
    @(negedge clk); start = 1'b1; frames = 8'd1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(row == 10'd1 && ckv && spv && !le) && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("abort_reached_gate_on", {row, ckv, spv, le}, {10'd1, 1'b1, 1'b1, 1'b0});
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_idle", outv(), IDLE_V);
    chk("abort_no_done", done, 0);
    ok = 1'b1;
    repeat (20) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0; end
    chk("abort_stays_idle", ok, 1);
    abort = 1'b1; start = 1'b1; frames = 8'd1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", {busy, done}, 2'b00);
    run_pass(1, 1'b0, 1'b0);

    // Asynchronous reset mid-LDATA, then a zero-frame start.
    @(negedge clk); start = 1'b1; frames = 8'd2;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(cl && !sph) && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("rst_reached_ldata", {cl, sph}, 2'b10);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_idle", outv(), IDLE_V);
    chk("async_rst_no_done", done, 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    ok = 1'b1;
    repeat (5) begin @(negedge clk); if (outv() !== IDLE_V || done !== 1'b0) ok = 1'b0; end
    chk("no_resume_after_rst", ok, 1);
    start = 1'b1; frames = 8'd0;
    @(negedge clk); start = 1'b0;
    chk("zero_frames_done", {done, busy, spv}, 3'b101);
    ok = 1'b1;
    repeat (4) begin @(negedge clk); if (done !== 1'b0 || spv !== 1'b1 || busy !== 1'b0) ok = 1'b0; end
    chk("zero_frames_quiet", ok, 1);

    // Random passes.
    for (int k = 0; k < 3; k++) run_pass($urandom_range(1, 3), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
